// File: rtl/bpred_pkg.sv
// Shared gshare predictor types: branch queue entry, index hash and 2-bit counter encodings.
// Index fields are sized to BPRED_MAX_W; users keep the low BPRED_WIDTH bits.
package bpred_pkg;

  localparam int BPRED_WIDTH_DEF = 10;
  localparam int BPRED_MAX_W     = 16;

  typedef logic [BPRED_MAX_W-1:0] bpred_idx_t;

  typedef struct packed {
    bpred_idx_t index;
    logic       predicted;
  } bq_entry_t;

  // 2-bit saturating counter states, MSB is the predicted direction
  typedef enum logic [1:0] {
    STRONGLY_NOT_TAKEN = 2'b00,
    WEAKLY_NOT_TAKEN   = 2'b01,
    WEAKLY_TAKEN       = 2'b10,
    STRONGLY_TAKEN     = 2'b11
  } ctr_state_t;

  function automatic bpred_idx_t bpred_hash(input bpred_idx_t pc_bits, input bpred_idx_t ghr);
    return pc_bits ^ ghr;
  endfunction

endpackage

// File: rtl/branch_queue.sv
// In-order FIFO of predicted branches awaiting resolution; head is visible combinationally.
// Push is refused while full even with a same-cycle pop; flush empties the queue in one edge.
module branch_queue
  import bpred_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_Clk,
  input  logic      i_Reset,
  input  logic      push,
  input  bq_entry_t push_dat,
  input  logic      pop,
  input  logic      flush,
  output logic      full,
  output logic      empty,
  output bq_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  bq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/branch_history_unit.sv
// gshare front end: PC^GHR lookup index, in-flight branch queue, GHR repair on mispredict/flush.
// Index is combinational; table update pulses one cycle after resolution (never back-to-back); fetch stalls on o_Queue_Full.
module branch_history_unit
  import bpred_pkg::*;
#(
  parameter int BPRED_WIDTH = BPRED_WIDTH_DEF,
  parameter int PC_WIDTH    = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Fetch_Branch,
  input  logic [PC_WIDTH-1:0]    i_Fetch_PC,
  output logic [BPRED_WIDTH-1:0] o_Index,
  input  logic                   i_Prediction,
  output logic                   o_Queue_Full,
  input  logic                   i_ALU_Branch_Valid,
  input  logic                   i_ALU_Branch_Outcome,
  input  logic                   i_Flush,
  output logic                   o_Update_Valid,
  output logic [BPRED_WIDTH-1:0] o_Resolution_Index,
  output logic                   o_Update_Outcome,
  output logic                   o_Mispredict
);

  logic [BPRED_WIDTH-1:0] spec_ghr;
  logic [BPRED_WIDTH-1:0] commit_ghr;
  logic [BPRED_WIDTH-1:0] commit_ghr_nxt;
  logic [BPRED_WIDTH-1:0] head_index;

  bpred_idx_t pc_bits_ext;
  bpred_idx_t hash_ext;
  bq_entry_t  push_dat;
  bq_entry_t  head;

  logic q_empty;
  logic resolve;
  logic mispredict;
  logic squash;
  logic accept;

  logic                   pend_vld;
  logic [BPRED_WIDTH-1:0] pend_index;
  logic                   pend_outcome;
  logic                   pend_misp;
  logic                   emit_pend;
  logic                   emit_new;
  logic                   park_new;

  assign pc_bits_ext = bpred_idx_t'(i_Fetch_PC[BPRED_WIDTH+1:2]);
  assign hash_ext    = bpred_hash(pc_bits_ext, bpred_idx_t'(spec_ghr));
  assign o_Index     = hash_ext[BPRED_WIDTH-1:0];
  assign head_index  = head.index[BPRED_WIDTH-1:0];

  if (BPRED_WIDTH < BPRED_MAX_W) begin : g_idx_pad
    logic unused_idx_hi;
    assign unused_idx_hi = ^{hash_ext[BPRED_MAX_W-1:BPRED_WIDTH], head.index[BPRED_MAX_W-1:BPRED_WIDTH]};
  end

  if (PC_WIDTH > BPRED_WIDTH + 2) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^i_Fetch_PC[PC_WIDTH-1:BPRED_WIDTH+2];
  end

  logic unused_pc_lo;
  assign unused_pc_lo = ^i_Fetch_PC[1:0];

  // Mispredict and flush both squash, and either one beats a same-cycle fetch
  assign resolve        = i_ALU_Branch_Valid && !q_empty;
  assign mispredict     = resolve && (i_ALU_Branch_Outcome != head.predicted);
  assign squash         = mispredict || i_Flush;
  assign accept         = i_Fetch_Branch && !o_Queue_Full && !squash;
  assign commit_ghr_nxt = resolve ? {commit_ghr[BPRED_WIDTH-2:0], i_ALU_Branch_Outcome} : commit_ghr;

  assign push_dat.index     = bpred_idx_t'(o_Index);
  assign push_dat.predicted = i_Prediction;

  branch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .push     (accept),
    .push_dat (push_dat),
    .pop      (resolve),
    .flush    (squash),
    .full     (o_Queue_Full),
    .empty    (q_empty),
    .head     (head)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      spec_ghr   <= '0;
      commit_ghr <= '0;
    end else begin
      commit_ghr <= commit_ghr_nxt;
      if (squash) begin
        spec_ghr <= commit_ghr_nxt;
      end else if (accept) begin
        spec_ghr <= {spec_ghr[BPRED_WIDTH-2:0], i_Prediction};
      end
    end
  end

  // A pending update only exists in the cycle after a pulse, so it can always go out next
  assign emit_pend = pend_vld && !o_Update_Valid;
  assign emit_new  = resolve && !o_Update_Valid && !pend_vld;
  assign park_new  = resolve && !emit_new;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      pend_vld     <= 1'b0;
      pend_index   <= '0;
      pend_outcome <= 1'b0;
      pend_misp    <= 1'b0;
    end else if (park_new) begin
      pend_vld     <= 1'b1;
      pend_index   <= head_index;
      pend_outcome <= i_ALU_Branch_Outcome;
      pend_misp    <= mispredict;
    end else if (emit_pend) begin
      pend_vld     <= 1'b0;
    end
  end

  // Index and outcome only move on a pulse and hold until the next one
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Update_Valid     <= 1'b0;
      o_Mispredict       <= 1'b0;
      o_Resolution_Index <= '0;
      o_Update_Outcome   <= 1'b0;
    end else if (emit_pend) begin
      o_Update_Valid     <= 1'b1;
      o_Mispredict       <= pend_misp;
      o_Resolution_Index <= pend_index;
      o_Update_Outcome   <= pend_outcome;
    end else if (emit_new) begin
      o_Update_Valid     <= 1'b1;
      o_Mispredict       <= mispredict;
      o_Resolution_Index <= head_index;
      o_Update_Outcome   <= i_ALU_Branch_Outcome;
    end else begin
      o_Update_Valid     <= 1'b0;
      o_Mispredict       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_history_unit.sv
// Bench for branch_history_unit: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_branch_history_unit;

  localparam int BW = 4;
  localparam int PW = 32;
  localparam int QD = 4;

  localparam logic [PW-1:0] P0 = 32'h0000_0040;
  localparam logic [PW-1:0] P4 = 32'h1000_0010;
  localparam logic [PW-1:0] P5 = 32'hABC0_0017;

  logic          i_Clk = 1'b0;
  logic          i_Reset;
  logic          i_Fetch_Branch;
  logic [PW-1:0] i_Fetch_PC;
  logic [BW-1:0] o_Index;
  logic          i_Prediction;
  logic          o_Queue_Full;
  logic          i_ALU_Branch_Valid;
  logic          i_ALU_Branch_Outcome;
  logic          i_Flush;
  logic          o_Update_Valid;
  logic [BW-1:0] o_Resolution_Index;
  logic          o_Update_Outcome;
  logic          o_Mispredict;

  branch_history_unit #(
    .BPRED_WIDTH (BW),
    .PC_WIDTH    (PW),
    .QUEUE_DEPTH (QD)
  ) dut (
    .i_Clk                (i_Clk),
    .i_Reset              (i_Reset),
    .i_Fetch_Branch       (i_Fetch_Branch),
    .i_Fetch_PC           (i_Fetch_PC),
    .o_Index              (o_Index),
    .i_Prediction         (i_Prediction),
    .o_Queue_Full         (o_Queue_Full),
    .i_ALU_Branch_Valid   (i_ALU_Branch_Valid),
    .i_ALU_Branch_Outcome (i_ALU_Branch_Outcome),
    .i_Flush              (i_Flush),
    .o_Update_Valid       (o_Update_Valid),
    .o_Resolution_Index   (o_Resolution_Index),
    .o_Update_Outcome     (o_Update_Outcome),
    .o_Mispredict         (o_Mispredict)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          fb;
    logic [PW-1:0] pc;
    logic          pred;
    logic          av;
    logic          ao;
    logic          fl;
    logic [BW-1:0] x_idx;
    logic          x_uv;
    logic          x_misp;
    logic [BW-1:0] x_ridx;
    logic          x_rout;
  } vec_t;

  vec_t tbl[23];

  typedef struct {
    logic [BW-1:0] idx;
    logic          pred;
  } ment_t;

  typedef struct {
    logic [BW-1:0] idx;
    logic          out;
    logic          misp;
  } mupd_t;

  ment_t         mq[$];
  mupd_t         bl[$];
  logic [BW-1:0] m_sg, m_cg, m_ridx, x_idx;
  logic          m_uv, m_misp, m_rout, x_full;

  function automatic vec_t mk(input logic fb, input logic [PW-1:0] pc, input logic pred,
                              input logic av, input logic ao, input logic fl,
                              input logic [BW-1:0] xi, input logic xu, input logic xm,
                              input logic [BW-1:0] xr, input logic xo);
    vec_t v;
    v.fb = fb; v.pc = pc; v.pred = pred; v.av = av; v.ao = ao; v.fl = fl;
    v.x_idx = xi; v.x_uv = xu; v.x_misp = xm; v.x_ridx = xr; v.x_rout = xo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fb, input logic [PW-1:0] pc, input logic pred,
                       input logic av, input logic ao, input logic fl);
    i_Fetch_Branch       = fb;
    i_Fetch_PC           = pc;
    i_Prediction         = pred;
    i_ALU_Branch_Valid   = av;
    i_ALU_Branch_Outcome = ao;
    i_Flush              = fl;
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, P0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_Reset = 1'b1;
    tick();
    tick();
    i_Reset = 1'b0;
  endtask

  task automatic chk_upd(input string tag, input logic uv, input logic misp,
                         input logic [BW-1:0] ridx, input logic rout);
    chk({tag, " upd_valid"}, o_Update_Valid, uv);
    chk({tag, " mispredict"}, o_Mispredict, misp);
    chk({tag, " res_index"}, o_Resolution_Index, ridx);
    chk({tag, " outcome"}, o_Update_Outcome, rout);
  endtask

  initial begin
    //            fb  pc  pr av ao fl  idx   uv ms ridx  out
    tbl[0]  = mk(1, P0, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0);
    tbl[1]  = mk(0, P0, 0, 0, 0, 0, 4'h1, 0, 0, 4'h0, 0);
    tbl[2]  = mk(1, P4, 1, 0, 0, 0, 4'h5, 0, 0, 4'h0, 0);
    tbl[3]  = mk(0, P0, 0, 1, 1, 0, 4'h3, 1, 0, 4'h0, 1);
    tbl[4]  = mk(0, P0, 0, 1, 1, 0, 4'h3, 0, 0, 4'h0, 1);
    tbl[5]  = mk(0, P0, 0, 0, 0, 0, 4'h3, 1, 0, 4'h5, 1);
    tbl[6]  = mk(0, P0, 0, 0, 0, 0, 4'h3, 0, 0, 4'h5, 1);
    tbl[7]  = mk(1, P0, 0, 0, 0, 0, 4'h3, 0, 0, 4'h5, 1);
    tbl[8]  = mk(0, P0, 0, 0, 0, 1, 4'h6, 0, 0, 4'h5, 1);
    tbl[9]  = mk(0, P0, 0, 0, 0, 0, 4'h3, 0, 0, 4'h5, 1);
    tbl[10] = mk(0, P0, 0, 1, 0, 0, 4'h3, 0, 0, 4'h5, 1);
    tbl[11] = mk(0, P0, 0, 0, 0, 0, 4'h3, 0, 0, 4'h5, 1);
    tbl[12] = mk(1, P0, 1, 0, 0, 0, 4'h3, 0, 0, 4'h5, 1);
    tbl[13] = mk(1, P0, 1, 0, 0, 0, 4'h7, 0, 0, 4'h5, 1);
    tbl[14] = mk(1, P0, 1, 0, 0, 0, 4'hF, 0, 0, 4'h5, 1);
    tbl[15] = mk(1, P0, 1, 1, 0, 0, 4'hF, 1, 1, 4'h3, 0);
    tbl[16] = mk(0, P0, 0, 0, 0, 0, 4'h6, 0, 0, 4'h3, 0);
    tbl[17] = mk(0, P0, 0, 1, 1, 0, 4'h6, 0, 0, 4'h3, 0);
    tbl[18] = mk(1, P0, 0, 0, 0, 0, 4'h6, 0, 0, 4'h3, 0);
    tbl[19] = mk(1, P0, 1, 0, 0, 0, 4'hC, 0, 0, 4'h3, 0);
    tbl[20] = mk(0, P0, 0, 1, 0, 1, 4'h9, 1, 0, 4'h6, 0);
    tbl[21] = mk(0, P0, 0, 0, 0, 0, 4'hC, 0, 0, 4'h6, 0);
    tbl[22] = mk(0, P0, 0, 1, 1, 0, 4'hC, 0, 0, 4'h6, 0);

    drive(1'b0, P0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_Reset = 1'b1;
    #2;
    chk_upd("reset", 1'b0, 1'b0, 4'h0, 1'b0);
    chk("reset full", o_Queue_Full, 1'b0);
    chk("reset index", o_Index, 4'h0);
    tick();
    tick();
    i_Reset = 1'b0;

    for (int r = 0; r < 23; r++) begin
      drive(tbl[r].fb, tbl[r].pc, tbl[r].pred, tbl[r].av, tbl[r].ao, tbl[r].fl);
      #1;
      chk($sformatf("tbl%0d index", r), o_Index, tbl[r].x_idx);
      chk($sformatf("tbl%0d full", r), o_Queue_Full, 1'b0);
      tick();
      chk_upd($sformatf("tbl%0d", r), tbl[r].x_uv, tbl[r].x_misp, tbl[r].x_ridx, tbl[r].x_rout);
    end

    // Fill to capacity, then refused pushes (alone and with a same-cycle pop)
    apply_reset();
    for (int i = 0; i < QD; i++) begin
      drive(1'b1, P0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk($sformatf("fill%0d full", i), o_Queue_Full, 1'b0);
      tick();
    end
    chk("full after fill", o_Queue_Full, 1'b1);
    drive(1'b1, P0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("full refused push", o_Queue_Full, 1'b1);
    chk("ghr held on refused push", o_Index, 4'h0);
    drive(1'b1, P0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("full clears after pop", o_Queue_Full, 1'b0);
    chk("ghr held on refused push+pop", o_Index, 4'h0);
    chk_upd("pop while full", 1'b1, 1'b0, 4'h0, 1'b0);
    drive(1'b1, P0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("refill full", o_Queue_Full, 1'b1);
    chk("refill index", o_Index, 4'h1);

    // Async reset in the middle of an update pulse with entries still queued
    apply_reset();
    drive(1'b1, P5, 1'b1, 1'b0, 1'b0, 1'b0); #1; chk("rst seq idx0", o_Index, 4'h5); tick();
    drive(1'b1, P5, 1'b1, 1'b0, 1'b0, 1'b0); #1; chk("rst seq idx1", o_Index, 4'h4); tick();
    drive(1'b1, P5, 1'b1, 1'b0, 1'b0, 1'b0); #1; chk("rst seq idx2", o_Index, 4'h6); tick();
    drive(1'b0, P5, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_upd("pre-reset pulse", 1'b1, 1'b0, 4'h5, 1'b1);
    drive(1'b0, P5, 1'b0, 1'b0, 1'b0, 1'b0);
    i_Reset = 1'b1;
    #1;
    chk_upd("mid-pulse reset", 1'b0, 1'b0, 4'h0, 1'b0);
    chk("mid-pulse reset full", o_Queue_Full, 1'b0);
    chk("mid-pulse reset index", o_Index, 4'h5);
    #2;
    i_Reset = 1'b0;
    drive(1'b0, P5, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_upd("post-reset empty resolve", 1'b0, 1'b0, 4'h0, 1'b0);
    drive(1'b0, P5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post-reset no late pulse", o_Update_Valid, 1'b0);
    chk("post-reset index", o_Index, 4'h5);

    // Random traffic against a queue-level reference
    apply_reset();
    m_sg = '0; m_cg = '0; m_uv = 1'b0; m_misp = 1'b0; m_ridx = '0; m_rout = 1'b0;
    mq.delete();
    bl.delete();
    for (int c = 0; c < 1500; c++) begin
      logic          fb, pred, av, ao, fl, res, mis, sq;
      logic [PW-1:0] pc;
      ment_t         h;
      mupd_t         u;
      fb   = ($urandom_range(9) < 7);
      pc   = $urandom;
      pred = 1'($urandom_range(1));
      av   = (bl.size() == 0) && ($urandom_range(9) < 4);
      ao   = 1'($urandom_range(1));
      fl   = ($urandom_range(24) == 0);
      drive(fb, pc, pred, av, ao, fl);
      #1;
      x_idx  = pc[BW+1:2] ^ m_sg;
      x_full = (mq.size() == QD);
      chk($sformatf("rnd%0d index", c), o_Index, x_idx);
      chk($sformatf("rnd%0d full", c), o_Queue_Full, x_full);

      res = av && (mq.size() > 0);
      mis = 1'b0;
      if (res) begin
        h    = mq.pop_front();
        mis  = (ao != h.pred);
        m_cg = {m_cg[BW-2:0], ao};
        u.idx = h.idx; u.out = ao; u.misp = mis;
        bl.push_back(u);
      end
      sq = mis || fl;
      if (sq) begin
        mq.delete();
        m_sg = m_cg;
      end else if (fb && !x_full) begin
        h.idx = x_idx; h.pred = pred;
        mq.push_back(h);
        m_sg = {m_sg[BW-2:0], pred};
      end
      if (!m_uv && bl.size() > 0) begin
        u      = bl.pop_front();
        m_uv   = 1'b1;
        m_misp = u.misp;
        m_ridx = u.idx;
        m_rout = u.out;
      end else begin
        m_uv   = 1'b0;
        m_misp = 1'b0;
      end

      tick();
      chk_upd($sformatf("rnd%0d", c), m_uv, m_misp, m_ridx, m_rout);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
